// File: rtl/control_ajuste_pkg.sv
// Shared PS/2 scancodes, field-group encodings and state types for the
// clock edit controller and the field counters.
package control_ajuste_pkg;

  localparam logic [7:0] SC_EDIT  = 8'h7D;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_INC   = 8'h73;
  localparam logic [7:0] SC_DEC   = 8'h72;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [1:0] EN_NONE  = 2'd0;
  localparam logic [1:0] EN_HORA  = 2'd1;
  localparam logic [1:0] EN_FECHA = 2'd2;
  localparam logic [1:0] EN_CRONO = 2'd3;

  localparam logic [7:0] ESTADO_EDIT = 8'h7D;

  typedef enum logic { LISTO, ROMPER } filtro_t;
  typedef enum logic [1:0] { NORMAL, EDITAR, SALIR } modo_t;

  // Rotates the selected field group through hora -> fecha -> cronometro.
  function automatic logic [1:0] en_step(input logic [1:0] cur, input logic right);
    case (cur)
      EN_HORA:  return right ? EN_FECHA : EN_CRONO;
      EN_FECHA: return right ? EN_CRONO : EN_HORA;
      default:  return right ? EN_HORA  : EN_FECHA;
    endcase
  endfunction

endpackage

// File: rtl/control_ajuste_filtro.sv
// PS/2 byte filter: drops F0 plus the byte after it, ignores E0 prefixes,
// forwards make codes one cycle after got_data.
module filtro_ps2
  import control_ajuste_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       got_data,
  input  logic [7:0] dato,
  output logic [7:0] codigo,
  output logic       codigo_ok
);

  filtro_t st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= LISTO;
      codigo    <= 8'h00;
      codigo_ok <= 1'b0;
    end else begin
      codigo_ok <= 1'b0;
      if (got_data && dato != SC_EXT) begin
        if (st == ROMPER) begin
          st <= LISTO;
        end else if (dato == SC_BREAK) begin
          st <= ROMPER;
        end else begin
          codigo    <= dato;
          codigo_ok <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/control_ajuste.sv
// Keyboard-driven edit-mode controller: selects field group, forwards
// inc/dec codes, and ends edits by enter, esc or inactivity timeout.
module control_ajuste
  import control_ajuste_pkg::*;
#(
  parameter int              N_TO  = 27,
  parameter logic [N_TO-1:0] T_MAX = 27'd100_000_000
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       got_data,
  input  logic [7:0] dato,
  output logic [7:0] estado,
  output logic [1:0] en,
  output logic [7:0] Cambio,
  output logic       cambio_ok,
  output logic       commit,
  output logic       abort
);

  localparam logic [N_TO-1:0] T_LAST = T_MAX - {{(N_TO-1){1'b0}}, 1'b1};

  logic [7:0]      codigo;
  logic            codigo_ok;
  modo_t           modo;
  logic [N_TO-1:0] cnt;

  filtro_ps2 u_filtro (
    .clk       (clk),
    .rst       (rst),
    .got_data  (got_data),
    .dato      (dato),
    .codigo    (codigo),
    .codigo_ok (codigo_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modo      <= NORMAL;
      cnt       <= '0;
      estado    <= 8'h00;
      en        <= EN_NONE;
      Cambio    <= 8'h00;
      cambio_ok <= 1'b0;
      commit    <= 1'b0;
      abort     <= 1'b0;
    end else begin
      cambio_ok <= 1'b0;
      commit    <= 1'b0;
      abort     <= 1'b0;
      case (modo)
        NORMAL: begin
          cnt    <= '0;
          estado <= 8'h00;
          en     <= EN_NONE;
          if (codigo_ok && codigo == SC_EDIT) begin
            modo   <= EDITAR;
            estado <= ESTADO_EDIT;
            en     <= EN_HORA;
          end
        end
        EDITAR: begin
          // A code in the same cycle as the timeout wins and restarts the timer.
          if (codigo_ok) begin
            cnt <= '0;
            case (codigo)
              SC_RIGHT: en <= en_step(en, 1'b1);
              SC_LEFT:  en <= en_step(en, 1'b0);
              SC_INC, SC_DEC: begin
                Cambio    <= codigo;
                cambio_ok <= 1'b1;
              end
              SC_ENTER: begin
                modo   <= SALIR;
                estado <= 8'h00;
                en     <= EN_NONE;
                commit <= 1'b1;
              end
              SC_ESC: begin
                modo   <= SALIR;
                estado <= 8'h00;
                en     <= EN_NONE;
                abort  <= 1'b1;
              end
              default: ;
            endcase
          end else if (cnt == T_LAST) begin
            modo   <= SALIR;
            estado <= 8'h00;
            en     <= EN_NONE;
            abort  <= 1'b1;
          end else begin
            cnt <= cnt + {{(N_TO-1){1'b0}}, 1'b1};
          end
        end
        SALIR: begin
          modo <= NORMAL;
          cnt  <= '0;
        end
        default: modo <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_control_ajuste.sv
// Bench for control_ajuste: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_control_ajuste;

  localparam int T_MAX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       got_data = 1'b0;
  logic [7:0] dato = 8'h00;
  logic [7:0] estado;
  logic [1:0] en;
  logic [7:0] Cambio;
  logic       cambio_ok;
  logic       commit;
  logic       abort;

  int total = 0;
  int bad = 0;
  int n_ok = 0, n_commit = 0, n_abort = 0;

  control_ajuste #(.N_TO(5), .T_MAX(5'd16)) dut (
    .clk       (clk),
    .rst       (rst),
    .got_data  (got_data),
    .dato      (dato),
    .estado    (estado),
    .en        (en),
    .Cambio    (Cambio),
    .cambio_ok (cambio_ok),
    .commit    (commit),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 normal, 1 editing, 2 leaving. Accepted codes reach the
  // mode logic one cycle after the byte; outputs show the new mode at once.
  int         m_mode, m_en, m_idle;
  bit         m_skip, m_has;
  logic [7:0] m_code, e_cambio;
  bit         e_ok, e_commit, e_abort;

  task automatic model_reset();
    m_mode = 0; m_en = 0; m_idle = 0; m_skip = 0; m_has = 0;
    m_code = 8'h00; e_cambio = 8'h00; e_ok = 0; e_commit = 0; e_abort = 0;
  endtask

  task automatic model_step();
    bit         use_code;
    logic [7:0] c;
    use_code = m_has;
    c = m_code;
    m_has = 0;
    if (got_data && dato != 8'hE0) begin
      if (m_skip) m_skip = 0;
      else if (dato == 8'hF0) m_skip = 1;
      else begin m_has = 1; m_code = dato; end
    end
    e_ok = 0; e_commit = 0; e_abort = 0;
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (use_code && c == 8'h7D) begin m_mode = 1; m_en = 1; m_idle = 0; end
    end else if (use_code) begin
      m_idle = 0;
      if (c == 8'h74) m_en = m_en % 3 + 1;
      else if (c == 8'h6B) m_en = (m_en + 1) % 3 + 1;
      else if (c == 8'h73 || c == 8'h72) begin e_cambio = c; e_ok = 1; end
      else if (c == 8'h5A) begin m_mode = 2; e_commit = 1; end
      else if (c == 8'h76) begin m_mode = 2; e_abort = 1; end
    end else begin
      m_idle++;
      if (m_idle == T_MAX) begin m_mode = 2; e_abort = 1; end
    end
    if (m_mode != 1) m_en = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("estado", estado, (m_mode == 1) ? 8'h7D : 8'h00);
      chk("en", en, m_en);
      chk("cambio", Cambio, e_cambio);
      chk("cambio_ok", cambio_ok, e_ok);
      chk("commit", commit, e_commit);
      chk("abort", abort, e_abort);
      chk("exclusive", 32'(cambio_ok) + 32'(commit) + 32'(abort) <= 1, 1);
      if (cambio_ok === 1'b1) n_ok++;
      if (commit === 1'b1) n_commit++;
      if (abort === 1'b1) n_abort++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    got_data = 1'b1;
    dato = b;
    @(negedge clk);
    got_data = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pool [11] = '{8'h7D, 8'h74, 8'h6B, 8'h73, 8'h72, 8'h5A,
                            8'h76, 8'hF0, 8'hE0, 8'h1C, 8'h7D};
  int ok0, ab0, cm0;

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("reset_estado", estado, 8'h00);
    chk("reset_en", en, 2'd0);
    chk("reset_pulses", {cambio_ok, commit, abort}, 3'b000);

    send(8'h7D); send(8'h74); idle(2);
    chk("enter_estado", estado, 8'h7D);
    chk("enter_right_en", en, 2'd2);

    ok0 = n_ok;
    send(8'h73); send(8'hF0); send(8'h73); idle(3);
    chk("one_cambio_pulse", n_ok - ok0, 1);
    chk("cambio_value", Cambio, 8'h73);

    send(8'h74); send(8'h74); idle(2);
    chk("wrap_to_hora", en, 2'd1);
    send(8'h6B); idle(2);
    chk("left_from_hora", en, 2'd3);
    send(8'h74); idle(2);
    chk("right_from_crono", en, 2'd1);
    send(8'h7D); idle(2);
    chk("7d_ignored_edit", estado, 8'h7D);

    cm0 = n_commit;
    send(8'h5A); idle(3);
    chk("commit_once", n_commit - cm0, 1);
    chk("after_commit_estado", estado, 8'h00);
    chk("after_commit_en", en, 2'd0);

    ab0 = n_abort;
    send(8'h7D); idle(T_MAX + 4);
    chk("timeout_abort", n_abort - ab0, 1);
    chk("timeout_estado", estado, 8'h00);

    ab0 = n_abort;
    send(8'h7D); idle(13); send(8'h74); idle(10);
    chk("late_code_no_abort", n_abort - ab0, 0);
    chk("late_code_still_edit", estado, 8'h7D);
    chk("late_code_en", en, 2'd2);

    send(8'h74); idle(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {estado, en, Cambio, cambio_ok, commit, abort}, 21'd0);
    ab0 = n_abort; cm0 = n_commit;
    idle(2);
    rst = 1'b0;
    idle(6);
    chk("no_pulse_after_rst", (n_abort - ab0) + (n_commit - cm0), 0);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) < 4) begin
        got_data = 1'b1;
        dato = ($urandom_range(0, 15) == 0) ? 8'($urandom) : pool[$urandom_range(0, 10)];
      end else begin
        got_data = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) idle($urandom_range(10, 20));
    end
    @(negedge clk);
    got_data = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_ajuste.md
CONTROL_AJUSTE -- requirements
Module: control_ajuste

Interface
REQ-001 SHALL have parameter N_TO, default 27, meaning width of the inactivity timeout counter.
REQ-002 SHALL have parameter T_MAX, default 27'd100_000_000, meaning idle cycles before edit mode auto-exits.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port got_data, input, 1, one-cycle strobe meaning a PS/2 byte is valid on dato.
REQ-006 SHALL have port dato, input, 8, the raw PS/2 scancode byte.
REQ-007 SHALL have port estado, output, 8, edit-mode flag: 8'h7D while editing, 8'h00 otherwise.
REQ-008 SHALL have port en, output, 2, field-group select: 0 none, 1 hora, 2 fecha, 3 cronometro.
REQ-009 SHALL have port Cambio, output, 8, filtered make code forwarded to the field counters.
REQ-010 SHALL have port cambio_ok, output, 1, one-cycle strobe qualifying Cambio; it drives the counters' got_data.
REQ-011 SHALL have port commit, output, 1, one-cycle pulse when an edit is accepted.
REQ-012 SHALL have port abort, output, 1, one-cycle pulse when an edit is cancelled or times out.

Function
REQ-013 Scancode filter SHALL have states LISTO and ROMPER: byte 8'hF0 in LISTO goes to ROMPER; the next byte SHALL be discarded and the filter returns to LISTO.
REQ-014 Byte 8'hE0 SHALL be ignored with no state change; the following byte is treated as a normal code.
REQ-015 Only make codes accepted in LISTO (not F0/E0) SHALL reach the main FSM, one cycle after got_data.
REQ-016 Main FSM SHALL have states NORMAL, EDITAR and SALIR.
REQ-017 NORMAL: code 8'h7D SHALL enter EDITAR with en=1; all other codes are ignored; estado=0, en=0.
REQ-018 EDITAR: estado SHALL be 8'h7D; code 8'h74 (right) SHALL step en 1->2->3->1; 8'h6B (left) SHALL step en 1->3->2->1.
REQ-019 EDITAR: codes 8'h73 and 8'h72 SHALL be copied to Cambio with cambio_ok high for exactly one cycle; all other codes SHALL leave Cambio unchanged and keep cambio_ok low.
REQ-020 EDITAR: 8'h5A (enter) SHALL go to SALIR and raise commit; 8'h76 (esc) or the timeout SHALL go to SALIR and raise abort.
REQ-021 SALIR SHALL last exactly one cycle, with en=0 and estado=0, then return to NORMAL; bytes arriving in SALIR SHALL be dropped.
REQ-022 Timeout counter SHALL clear on entry to EDITAR and on every accepted code; otherwise it increments in EDITAR and fires when it equals T_MAX-1. It SHALL saturate and not wrap.
REQ-023 If a code and the timeout occur in the same cycle, the code SHALL win and the counter clears.
REQ-024 commit, abort and cambio_ok SHALL be mutually exclusive in every cycle.
REQ-025 Code 8'h7D received in EDITAR SHALL be ignored; it does not toggle mode.

Reset
REQ-026 rst high SHALL asynchronously force: filter to LISTO, FSM to NORMAL, estado=8'h00, en=2'd0, Cambio=8'h00, cambio_ok=0, commit=0, abort=0, timeout=0.
REQ-027 rst mid-edit SHALL not produce commit or abort, either during or after reset.

Structure
REQ-028 Scancode constants (7D, 74, 6B, 73, 72, 5A, 76, F0, E0) and the en encodings SHALL live in a shared package or include, common with the field counters.
REQ-029 The F0/E0 filter SHALL be a sub-module named filtro_ps2, with outputs codigo[7:0] and codigo_ok.

Verification
REQ-030 Reset, then bytes 7D, 74 -> estado=7D, en=2.
REQ-031 In EDITAR with en=2, bytes 73, F0, 73 -> exactly one cambio_ok pulse with Cambio=73; the break byte is swallowed.
REQ-032 en=1, byte 6B -> en=3; then byte 74 -> en=1.
REQ-033 Byte 5A -> commit for one cycle, one cycle of SALIR, then estado=0, en=0.
REQ-034 With T_MAX=16, enter EDITAR and stay idle 16 cycles -> abort pulse, return to NORMAL; a code arriving on the 16th cycle instead clears the timer and no abort occurs.
REQ-035 Assert rst while in EDITAR with en=3 -> all outputs 0 immediately, and no commit or abort after release.
